// File: rtl/elevator_pkg.sv
// Shared constants, FSM encoding and request-scan helpers for the elevator car controller.
package elevator_pkg;

    localparam int FLOOR_W    = 3;
    localparam int NUM_FLOORS = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } fsm_state_e;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (i > int'(floor))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (i < int'(floor))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] oh;
        oh        = '0;
        oh[floor] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Call/status bundle between the car controller and the hall panel / floor display.
interface elevator_car_ctrl_if;
    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    floornum;
    logic                  state;
    logic                  door_open;
    logic                  moving;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output call_req,
        input  floornum, state, door_open, moving, pending
    );

    modport slave (
        input  call_req,
        output floornum, state, door_open, moving, pending
    );

endinterface

// File: rtl/elevator_timer.sv
// Up-counter with synchronous clear and terminal-count flag; times both travel and dwell.
module elevator_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = en && (cnt == tc);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car-motion controller: latches calls, picks direction, steps floors on the travel
// timer and holds the door for a fixed dwell at each served floor.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    elevator_car_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] TRAVEL_TC = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_TC   = CNT_W'(DOOR_CYCLES - 1);

    fsm_state_e            fsm_q, fsm_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, step_floor;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d, clr;
    logic                  door_q, move_q;
    logic                  above, below, ahead_at_step;

    logic [CNT_W-1:0]      tmr_cnt, tmr_tc;
    logic                  tmr_clr, tmr_en, tmr_done;

    assign above = any_above(pend_q, floor_q);
    assign below = any_below(pend_q, floor_q);

    assign step_floor    = (dir_q == DIR_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    assign ahead_at_step = (dir_q == DIR_DOWN) ? any_below(pend_q, step_floor)
                                               : any_above(pend_q, step_floor);

    // Idle keeps the timer parked at zero, so entering MOVE/DOOR always starts from 0.
    assign tmr_en  = (fsm_q != IDLE);
    assign tmr_clr = (fsm_q == IDLE) || tmr_done;
    assign tmr_tc  = (fsm_q == DOOR) ? DOOR_TC : TRAVEL_TC;

    elevator_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc),
        .cnt   (tmr_cnt),
        .done  (tmr_done)
    );

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        fsm_d   = fsm_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        unique case (fsm_q)
            IDLE: begin
                if (pend_q[floor_q]) begin
                    fsm_d = DOOR;
                end else if (dir_q == DIR_UP) begin
                    if (above) begin
                        fsm_d = MOVE;
                    end else if (below) begin
                        dir_d = DIR_DOWN;
                        fsm_d = MOVE;
                    end
                end else begin
                    if (below) begin
                        fsm_d = MOVE;
                    end else if (above) begin
                        dir_d = DIR_UP;
                        fsm_d = MOVE;
                    end
                end
            end
            MOVE: begin
                if (tmr_done) begin
                    floor_d = step_floor;
                    if (pend_q[step_floor])  fsm_d = DOOR;
                    else if (ahead_at_step)  fsm_d = MOVE;
                    else                     fsm_d = IDLE;
                end
            end
            DOOR: begin
                if (tmr_done) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // A call for the floor being served (on entry or during dwell) is absorbed.
    assign clr    = ((fsm_q == DOOR) || (fsm_d == DOOR)) ? floor_onehot(floor_d) : '0;
    assign pend_d = (pend_q | bus.call_req) & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            floor_q <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= '0;
            door_q  <= 1'b0;
            move_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            door_q  <= (fsm_d == DOOR);
            move_q  <= (fsm_d == MOVE);
        end
    end

    assign bus.floornum  = floor_q;
    assign bus.state     = dir_q;
    assign bus.door_open = door_q;
    assign bus.moving    = move_q;
    assign bus.pending   = pend_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed scenarios plus randomized calls, checked every cycle against a countdown-based
// behavioural model of the car.
module tb_elevator_car_ctrl;
    import elevator_pkg::*;

    localparam int TRAVEL = 16;
    localparam int DWELL  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    elevator_car_ctrl_if bus ();

    elevator_car_ctrl #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DWELL),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = parked, 1 = travelling, 2 = door open; m_left counts down.
    int       m_floor;
    bit       m_dir;
    bit [7:0] m_pend;
    int       m_mode;
    int       m_left;
    int       prev_floor;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit requests_ahead(input bit [7:0] p, input int f, input bit d);
        for (int i = 0; i < 8; i++) begin
            if (p[i] && (d ? (i < f) : (i > f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1'b0; m_pend = '0; m_mode = 0; m_left = 0;
    endtask

    task automatic model_step(input bit [7:0] req);
        bit [7:0] np;
        int       nmode, nfloor;
        np = m_pend | req; nmode = m_mode; nfloor = m_floor;
        case (m_mode)
            0: begin
                if (m_pend[m_floor]) begin
                    nmode = 2; m_left = DWELL;
                end else if (requests_ahead(m_pend, m_floor, m_dir)) begin
                    nmode = 1; m_left = TRAVEL;
                end else if (requests_ahead(m_pend, m_floor, !m_dir)) begin
                    m_dir = !m_dir; nmode = 1; m_left = TRAVEL;
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    nfloor = m_dir ? m_floor - 1 : m_floor + 1;
                    if (m_pend[nfloor]) begin
                        nmode = 2; m_left = DWELL;
                    end else if (requests_ahead(m_pend, nfloor, m_dir)) begin
                        m_left = TRAVEL;
                    end else begin
                        nmode = 0;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) nmode = 0;
            end
        endcase
        if (m_mode == 2 || nmode == 2) np[nfloor] = 1'b0;
        m_pend = np; m_mode = nmode; m_floor = nfloor;
    endtask

    task automatic compare_all();
        int diff;
        check("floornum",  32'(bus.floornum),  32'(m_floor));
        check("state",     32'(bus.state),     32'(m_dir));
        check("door_open", 32'(bus.door_open), 32'(m_mode == 2));
        check("moving",    32'(bus.moving),    32'(m_mode == 1));
        check("pending",   32'(bus.pending),   32'(m_pend));
        check("door_move_excl", 32'(bus.door_open & bus.moving), 32'd0);
        if (!reset) begin
            diff = int'(bus.floornum) - prev_floor;
            check("floor_step", 32'((diff >= -1) && (diff <= 1)), 32'd1);
        end
        prev_floor = int'(bus.floornum);
    endtask

    task automatic tick(input logic [7:0] req);
        @(negedge clk);
        bus.call_req = req;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(req);
        #1;
        compare_all();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.door_open || bus.moving || bus.pending != 0) && n < budget) begin
            tick(8'h00);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, minf;
        int door_floors[$];
        logic [7:0] req;
        bit was_open;

        bus.call_req = '0;
        reset = 1'b1;
        prev_floor = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        @(negedge clk) reset = 1'b0;

        // Scenario 1: reset asserted mid-travel, checked before the next clock edge.
        tick(8'h80);
        repeat (20) tick(8'h00);
        check("t1_moving_before", 32'(bus.moving), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1 compare_all();
        repeat (3) tick(8'h00);
        @(negedge clk) reset = 1'b0;

        // Scenario 2: call at the current floor.
        tick(8'h01);
        check("t2_door_pre", 32'(bus.door_open), 32'd0);
        tick(8'h00);
        check("t2_door_rise", 32'(bus.door_open), 32'd1);
        check("t2_pend_clr", 32'(bus.pending[0]), 32'd0);
        hi = 0;
        while (bus.door_open && hi < 100) begin
            hi++;
            tick(8'h00);
        end
        check("t2_dwell", 32'(hi), 32'(DWELL));
        check("t2_idle", 32'(bus.moving | bus.door_open), 32'd0);

        // Scenario 3: travel 0 -> 3.
        tick(8'h08);
        n = 0;
        while (!bus.door_open && n < 200) begin
            tick(8'h00);
            n++;
        end
        check("t3_latency", 32'(n), 32'(3 * TRAVEL + 1));
        check("t3_floor", 32'(bus.floornum), 32'd3);
        check("t3_dir", 32'(bus.state), 32'd0);
        wait_idle("t3_drain", 200);

        // Scenario 4: requests on both sides; current direction wins.
        tick(8'h82);
        minf = 7; was_open = 1'b0; n = 0;
        while ((bus.door_open || bus.moving || bus.pending != 0) && n < 1000) begin
            if (bus.door_open && !was_open) door_floors.push_back(int'(bus.floornum));
            was_open = bus.door_open;
            if (int'(bus.floornum) < minf) minf = int'(bus.floornum);
            tick(8'h00);
            n++;
        end
        check("t4_budget", 32'(n < 1000), 32'd1);
        check("t4_stops", 32'(door_floors.size()), 32'd2);
        if (door_floors.size() == 2) begin
            check("t4_first", 32'(door_floors[0]), 32'd7);
            check("t4_second", 32'(door_floors[1]), 32'd1);
        end
        check("t4_min_floor", 32'(minf), 32'd1);
        check("t4_dir", 32'(bus.state), 32'd1);

        // Scenario 5: same-floor call absorbed during dwell, then reverse to floor 2.
        tick(8'h20);
        n = 0;
        while (!bus.door_open && n < 300) begin
            tick(8'h00);
            n++;
        end
        check("t5_floor5", 32'(bus.floornum), 32'd5);
        hi = 0;
        while (bus.door_open && hi < 100) begin
            hi++;
            tick((hi == 4) ? 8'h24 : 8'h00);
            if (hi == 4) check("t5_absorb", 32'(bus.pending), 32'h04);
        end
        check("t5_dwell", 32'(hi), 32'(DWELL));
        n = 0;
        while (!bus.door_open && n < 300) begin
            tick(8'h00);
            n++;
        end
        check("t5_floor2", 32'(bus.floornum), 32'd2);
        check("t5_dir", 32'(bus.state), 32'd1);
        wait_idle("t5_drain", 200);

        // Scenario 6: sparse random calls, then every request must be served.
        for (int i = 0; i < 10000; i++) begin
            req = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
            tick(req);
        end
        wait_idle("t6_drain", 3000);
        check("t6_all_served", 32'(bus.pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
